system_alarm_out: RTL and testbench
===================================

Name: system_alarm_out

Overview:
- Avalon-MM slave output port for the alarm-clock SoC; drives the buzzer pin `out_port`.
- Provides a software-settable static output level.
- Provides a hardware beep sequencer: N pulses of programmable high time and low time.
- Raises a maskable interrupt when a sequence completes, so the Nios II core need not bit-bang the buzzer.

Parameters:
- DIV_WIDTH, 16, width of the ON_LEN/OFF_LEN cycle counters.
- CNT_WIDTH, 8, width of the beep-count register (max 2^CNT_WIDTH-1 beeps).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous assert, active low
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  registered read data
- irq  out  1  interrupt, active high, level
- out_port  out  1  buzzer drive

Behaviour:
- Interface timing: one clock domain; reset is asynchronous and active-low on reset_n. A write occurs on a posedge where chipselect=1, write_n=0.
- Register map (unlisted bits read 0; writes to them are ignored):
  - addr0 DATA: r/w. Bit0 = static_level.
  - addr1 ON_LEN: r/w. [DIV_WIDTH-1:0] = high cycles per beep; value 0 is treated as 1.
  - addr2 OFF_LEN: r/w. [DIV_WIDTH-1:0] = low cycles between beeps; value 0 is treated as 1.
  - addr3 CTRL: write bit0 START, bit1 STOP, [CNT_WIDTH+7:8] COUNT. Read bit0 busy, [CNT_WIDTH+7:8] remaining.
  - addr4 IRQ_MASK: r/w. Bit0.
  - addr5 STATUS: bit0 done. Write with writedata[0]=1 clears done.
  - addr6, addr7: read 0; writes ignored.
- Read path: readdata <= mux(address) on every posedge, independent of chipselect. Latency is 1 cycle.
- Reset values: all registers 0, state IDLE, readdata=0, irq=0, out_port=0.
- Output logic:
  - out_port = static_level | (state==ON).
  - irq = done & IRQ_MASK[0].
- FSM states: IDLE, ON, OFF. busy = (state!=IDLE). timer is a DIV_WIDTH-bit down-counter.
- IDLE: a START write with COUNT>0 loads remaining=COUNT and timer=max(ON_LEN,1); the next state is ON. START with COUNT=0 is ignored.
- ON: timer decrements each cycle. When timer==1:
  - remaining decrements;
  - if the new remaining is 0, go to IDLE and set done;
  - otherwise load timer=max(OFF_LEN,1) and go to OFF.
- OFF: when timer==1, load timer=max(ON_LEN,1) and go to ON.
- Resulting waveform: out_port high for exactly max(ON_LEN,1) cycles per beep and low for max(OFF_LEN,1) cycles between beeps. The first high cycle begins the cycle after the START write.
- START while busy: ignored; COUNT is not reloaded.
- STOP (any state): next state IDLE, remaining=0, done unchanged. STOP and START in the same write: STOP wins.
- ON_LEN/OFF_LEN written mid-sequence: the new value takes effect at the next timer load only.
- done set and done clear in the same cycle: set wins.
- static_level=1: out_port stays 1 regardless of the sequencer; the sequence still runs and sets done.
- reset_n asserted mid-sequence: immediate return to IDLE with all reset values.

Optional Feature:
- Macro: SYSTEM_ALARM_OUT_REPEAT_EN.
- Defined:
  - CTRL bit2 REPEAT is latched on an accepted START and reads back at CTRL bit2.
  - With REPEAT latched, the last beep's ON→end transition sets done, reloads remaining=the latched COUNT, and goes to OFF. The sequence repeats until STOP.
  - STOP clears the latched REPEAT.
- Undefined: bit2 is ignored on write and reads 0; behaviour is exactly as above.

Test Plan:
- Reset check: assert reset_n=0 mid-sequence (ON, remaining=2) -> out_port=0, irq=0, readdata=0, CTRL reads 0 immediately; after release all registers read 0.
- Basic sequence: ON_LEN=3, OFF_LEN=2, IRQ_MASK=1, write CTRL COUNT=2 START -> out_port pattern 1,1,1,0,0,1,1,1 then 0. done=1 and irq=1 in the cycle after the last high. Write STATUS=1 -> irq=0.
- Zero lengths: ON_LEN=0, OFF_LEN=0, COUNT=3 -> 1,0,1,0,1 then idle. COUNT=0 START -> busy stays 0, out_port 0.
- STOP and collisions: STOP during the second beep of COUNT=5 -> out_port 0 next cycle, busy=0, done=0. Write STOP|START -> stays IDLE. START while busy with COUNT=9 -> remaining unaffected.
- Clear/set collision: write STATUS=1 on the same cycle done sets -> done reads 1. IRQ_MASK=0 with done=1 -> irq=0. Read DATA after writing 1 -> readdata=1 one cycle after address is presented.
- With SYSTEM_ALARM_OUT_REPEAT_EN: COUNT=1, REPEAT, ON_LEN=2, OFF_LEN=2 -> 1,1,0,0,1,1,… continuous, done set after each beep. STOP -> halt, CTRL bit2 reads 0.

Source files
------------

// File: rtl/system_alarm_out.sv
// Avalon-MM buzzer output port: static level plus an N-beep sequencer with a maskable done interrupt.
// Optional macro SYSTEM_ALARM_OUT_REPEAT_EN adds a CTRL REPEAT bit that loops the sequence until STOP.
module system_alarm_out #(
   parameter int unsigned DIV_WIDTH = 16,
   parameter int unsigned CNT_WIDTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        irq,
   output logic        out_port
);

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned CNT_LSB = 8;
   localparam int unsigned CNT_MSB = CNT_WIDTH + 7;

   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_ONLEN  = 3'd1;
   localparam logic [2:0] A_OFFLEN = 3'd2;
   localparam logic [2:0] A_CTRL   = 3'd3;
   localparam logic [2:0] A_MASK   = 3'd4;
   localparam logic [2:0] A_STATUS = 3'd5;

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

   state_t                 state_q, state_d;
   logic [DIV_WIDTH-1:0]   timer_q, timer_d;
   logic [DIV_WIDTH-1:0]   on_q, on_d, off_q, off_d;
   logic [CNT_WIDTH-1:0]   rem_q, rem_d;
   logic                   static_q, static_d;
   logic                   mask_q, mask_d;
   logic                   done_q, done_d;
   logic [DATA_W-1:0]      rd_d;
   logic                   out_d, irq_d;
`ifdef SYSTEM_ALARM_OUT_REPEAT_EN
   logic                   rep_q, rep_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
`endif

   logic                   wr, start, stop, done_set, done_clr;
   logic [CNT_WIDTH-1:0]   wr_count, rem_dec;
   logic [DIV_WIDTH-1:0]   on_eff, off_eff;
   logic                   unused_wdata;

   // Only some writedata bits are decoded; fold the rest so nothing dangles.
   assign unused_wdata = ^writedata;

   // Next-state, register-file updates and registered output values.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      rem_d    = rem_q;
      on_d     = on_q;
      off_d    = off_q;
      static_d = static_q;
      mask_d   = mask_q;
      done_set = 1'b0;
`ifdef SYSTEM_ALARM_OUT_REPEAT_EN
      rep_d    = rep_q;
      cnt_d    = cnt_q;
`endif
      wr       = chipselect && !write_n;
      start    = wr && (address == A_CTRL) && writedata[0];
      stop     = wr && (address == A_CTRL) && writedata[1];
      done_clr = wr && (address == A_STATUS) && writedata[0];
      wr_count = writedata[CNT_MSB:CNT_LSB];
      rem_dec  = rem_q - CNT_WIDTH'(1);
      // A zero length still produces one cycle.
      on_eff   = (on_q  == '0) ? DIV_WIDTH'(1) : on_q;
      off_eff  = (off_q == '0) ? DIV_WIDTH'(1) : off_q;

      if (wr && (address == A_DATA))   static_d = writedata[0];
      if (wr && (address == A_ONLEN))  on_d     = writedata[DIV_WIDTH-1:0];
      if (wr && (address == A_OFFLEN)) off_d    = writedata[DIV_WIDTH-1:0];
      if (wr && (address == A_MASK))   mask_d   = writedata[0];

      case (state_q)
         S_IDLE: begin
            if (start && (wr_count != '0)) begin
               state_d = S_ON;
               rem_d   = wr_count;
               timer_d = on_eff;
`ifdef SYSTEM_ALARM_OUT_REPEAT_EN
               rep_d   = writedata[2];
               cnt_d   = wr_count;
`endif
            end
         end
         S_ON: begin
            if (timer_q == DIV_WIDTH'(1)) begin
               rem_d = rem_dec;
               if (rem_dec == '0) begin
                  done_set = 1'b1;
                  state_d  = S_IDLE;
`ifdef SYSTEM_ALARM_OUT_REPEAT_EN
                  if (rep_q) begin
                     rem_d   = cnt_q;
                     timer_d = off_eff;
                     state_d = S_OFF;
                  end
`endif
               end else begin
                  timer_d = off_eff;
                  state_d = S_OFF;
               end
            end else begin
               timer_d = timer_q - DIV_WIDTH'(1);
            end
         end
         S_OFF: begin
            if (timer_q == DIV_WIDTH'(1)) begin
               timer_d = on_eff;
               state_d = S_ON;
            end else begin
               timer_d = timer_q - DIV_WIDTH'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // STOP overrides everything, including a simultaneous START.
      if (stop) begin
         state_d = S_IDLE;
         rem_d   = '0;
`ifdef SYSTEM_ALARM_OUT_REPEAT_EN
         rep_d   = 1'b0;
`endif
      end

      done_d = done_set || (done_q && !done_clr);
      out_d  = static_d || (state_d == S_ON);
      irq_d  = done_d && mask_d;

      rd_d = '0;
      case (address)
         A_DATA:   rd_d[0] = static_q;
         A_ONLEN:  rd_d[DIV_WIDTH-1:0] = on_q;
         A_OFFLEN: rd_d[DIV_WIDTH-1:0] = off_q;
         A_CTRL: begin
            rd_d[0] = (state_q != S_IDLE);
            rd_d[CNT_MSB:CNT_LSB] = rem_q;
`ifdef SYSTEM_ALARM_OUT_REPEAT_EN
            rd_d[2] = rep_q;
`endif
         end
         A_MASK:   rd_d[0] = mask_q;
         A_STATUS: rd_d[0] = done_q;
         default:  rd_d = '0;
      endcase
   end

   // State and register file.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         rem_q    <= '0;
         on_q     <= '0;
         off_q    <= '0;
         static_q <= 1'b0;
         mask_q   <= 1'b0;
         done_q   <= 1'b0;
         readdata <= '0;
         out_port <= 1'b0;
         irq      <= 1'b0;
`ifdef SYSTEM_ALARM_OUT_REPEAT_EN
         rep_q    <= 1'b0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         rem_q    <= rem_d;
         on_q     <= on_d;
         off_q    <= off_d;
         static_q <= static_d;
         mask_q   <= mask_d;
         done_q   <= done_d;
         readdata <= rd_d;
         out_port <= out_d;
         irq      <= irq_d;
`ifdef SYSTEM_ALARM_OUT_REPEAT_EN
         rep_q    <= rep_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_system_alarm_out.sv
// Self-checking bench for system_alarm_out: scoreboarded out_port/irq waveforms plus register reads.
module tb_system_alarm_out;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;
   logic        out_port;

   int n_cmp = 0;
   int n_mis = 0;

   typedef struct packed {logic o; logic i;} exp_t;
   exp_t sb[$];

   system_alarm_out dut (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .irq(irq), .out_port(out_port)
   );

   always #5 clk = ~clk;

   function automatic void push(input logic o, input logic i);
      exp_t e;
      e.o = o;
      e.i = i;
      sb.push_back(e);
   endfunction

   // All tasks enter and leave just after a falling edge.
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      @(negedge clk);
      d = readdata;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      exp_t e;
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), d);
         n_cmp++;
         if (d !== 32'h0) begin n_mis++; $display("FAIL reset_reg[%0d]: got %h expected 0", a, d); end
      end
      wr(3'd4, 32'h1);
      wr(3'd1, 32'd3);
      wr(3'd2, 32'd2);
      wr(3'd3, (32'd2 << 8) | 32'h1);
      push(1'b1, 1'b0); push(1'b1, 1'b0);
      for (int k = 0; sb.size() > 0; k++) begin
         e = sb.pop_front();
         n_cmp++;
         if (out_port !== e.o || irq !== e.i) begin
            n_mis++; $display("FAIL reset_wave[%0d]: got out=%b irq=%b expected out=%b irq=%b", k, out_port, irq, e.o, e.i);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (readdata !== 32'h0000_0201) begin n_mis++; $display("FAIL reset_pre_ctrl: got %h expected 00000201", readdata); end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (out_port !== 1'b0 || irq !== 1'b0 || readdata !== 32'h0) begin
         n_mis++; $display("FAIL reset_async: got out=%b irq=%b rd=%h expected 0 0 0", out_port, irq, readdata);
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), d);
         n_cmp++;
         if (d !== 32'h0) begin n_mis++; $display("FAIL reset_after[%0d]: got %h expected 0", a, d); end
      end
   endtask

   task automatic test_regs;
      logic [31:0] d;
      logic [31:0] exp_rd [8];
      wr(3'd0, 32'hFFFF_FFFE);
      wr(3'd1, 32'h0001_2345);
      wr(3'd2, 32'hFFFF_FFFF);
      wr(3'd4, 32'hFFFF_FFFE);
      wr(3'd6, 32'hFFFF_FFFF);
      wr(3'd7, 32'hFFFF_FFFF);
      exp_rd = '{32'h0, 32'h2345, 32'hFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), d);
         n_cmp++;
         if (d !== exp_rd[a]) begin n_mis++; $display("FAIL regs[%0d]: got %h expected %h", a, d, exp_rd[a]); end
      end
   endtask

   task automatic test_basic;
      logic [31:0] d;
      exp_t e;
      wr(3'd4, 32'h1);
      wr(3'd1, 32'd3);
      wr(3'd2, 32'd2);
      wr(3'd3, (32'd2 << 8) | 32'h1);
      push(1,0); push(1,0); push(1,0); push(0,0); push(0,0);
      push(1,0); push(1,0); push(1,0); push(0,1); push(0,1);
      for (int k = 0; sb.size() > 0; k++) begin
         e = sb.pop_front();
         n_cmp++;
         if (out_port !== e.o || irq !== e.i) begin
            n_mis++; $display("FAIL basic_wave[%0d]: got out=%b irq=%b expected out=%b irq=%b", k, out_port, irq, e.o, e.i);
         end
         @(negedge clk);
      end
      rd(3'd5, d);
      n_cmp++;
      if (d !== 32'h1) begin n_mis++; $display("FAIL basic_done: got %h expected 1", d); end
      rd(3'd3, d);
      n_cmp++;
      if (d !== 32'h0) begin n_mis++; $display("FAIL basic_ctrl_idle: got %h expected 0", d); end
      wr(3'd5, 32'h1);
      n_cmp++;
      if (irq !== 1'b0) begin n_mis++; $display("FAIL basic_irq_clr: got %b expected 0", irq); end
   endtask

   task automatic test_zero_len;
      logic [31:0] d;
      exp_t e;
      wr(3'd1, 32'd0);
      wr(3'd2, 32'd0);
      wr(3'd3, (32'd3 << 8) | 32'h1);
      push(1,0); push(0,0); push(1,0); push(0,0); push(1,0); push(0,1); push(0,1);
      for (int k = 0; sb.size() > 0; k++) begin
         e = sb.pop_front();
         n_cmp++;
         if (out_port !== e.o || irq !== e.i) begin
            n_mis++; $display("FAIL zero_wave[%0d]: got out=%b irq=%b expected out=%b irq=%b", k, out_port, irq, e.o, e.i);
         end
         @(negedge clk);
      end
      wr(3'd5, 32'h1);
      wr(3'd3, 32'h1);
      n_cmp++;
      if (out_port !== 1'b0) begin n_mis++; $display("FAIL zero_count_out: got %b expected 0", out_port); end
      rd(3'd3, d);
      n_cmp++;
      if (d !== 32'h0) begin n_mis++; $display("FAIL zero_count_busy: got %h expected 0", d); end
   endtask

   task automatic test_stop;
      logic [31:0] d;
      exp_t e;
      wr(3'd1, 32'd3);
      wr(3'd2, 32'd2);
      wr(3'd3, (32'd5 << 8) | 32'h1);
      push(1,0); push(1,0); push(1,0); push(0,0); push(0,0); push(1,0);
      for (int k = 0; sb.size() > 0; k++) begin
         e = sb.pop_front();
         n_cmp++;
         if (out_port !== e.o || irq !== e.i) begin
            n_mis++; $display("FAIL stop_wave[%0d]: got out=%b irq=%b expected out=%b irq=%b", k, out_port, irq, e.o, e.i);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (out_port !== 1'b1) begin n_mis++; $display("FAIL stop_mid_beep: got %b expected 1", out_port); end
      wr(3'd3, 32'h2);
      n_cmp++;
      if (out_port !== 1'b0) begin n_mis++; $display("FAIL stop_out: got %b expected 0", out_port); end
      rd(3'd3, d);
      n_cmp++;
      if (d !== 32'h0) begin n_mis++; $display("FAIL stop_ctrl: got %h expected 0", d); end
      rd(3'd5, d);
      n_cmp++;
      if (d !== 32'h0) begin n_mis++; $display("FAIL stop_done: got %h expected 0", d); end
      wr(3'd3, (32'd2 << 8) | 32'h3);
      n_cmp++;
      if (out_port !== 1'b0) begin n_mis++; $display("FAIL stopstart_out: got %b expected 0", out_port); end
      rd(3'd3, d);
      n_cmp++;
      if (d !== 32'h0) begin n_mis++; $display("FAIL stopstart_ctrl: got %h expected 0", d); end
      // START while busy must not reload COUNT.
      wr(3'd3, (32'd2 << 8) | 32'h1);
      wr(3'd3, (32'd9 << 8) | 32'h1);
      rd(3'd3, d);
      n_cmp++;
      if (d !== 32'h0000_0201) begin n_mis++; $display("FAIL busy_start_ctrl: got %h expected 00000201", d); end
      push(1,0); push(0,0); push(0,0); push(1,0); push(1,0); push(1,0); push(0,1); push(0,1);
      for (int k = 0; sb.size() > 0; k++) begin
         e = sb.pop_front();
         n_cmp++;
         if (out_port !== e.o || irq !== e.i) begin
            n_mis++; $display("FAIL busy_wave[%0d]: got out=%b irq=%b expected out=%b irq=%b", k, out_port, irq, e.o, e.i);
         end
         @(negedge clk);
      end
      wr(3'd5, 32'h1);
   endtask

   task automatic test_collision;
      logic [31:0] d;
      wr(3'd1, 32'd2);
      wr(3'd2, 32'd1);
      wr(3'd3, (32'd1 << 8) | 32'h1);
      @(negedge clk);
      wr(3'd5, 32'h1);
      rd(3'd5, d);
      n_cmp++;
      if (d !== 32'h1) begin n_mis++; $display("FAIL setclr_done: got %h expected 1", d); end
      n_cmp++;
      if (irq !== 1'b1) begin n_mis++; $display("FAIL setclr_irq: got %b expected 1", irq); end
      wr(3'd4, 32'h0);
      n_cmp++;
      if (irq !== 1'b0) begin n_mis++; $display("FAIL mask_irq: got %b expected 0", irq); end
   endtask

   task automatic test_static;
      logic [31:0] d;
      exp_t e;
      wr(3'd5, 32'h1);
      wr(3'd0, 32'h1);
      rd(3'd0, d);
      n_cmp++;
      if (d !== 32'h1) begin n_mis++; $display("FAIL data_read: got %h expected 1", d); end
      wr(3'd1, 32'd1);
      wr(3'd2, 32'd1);
      wr(3'd3, (32'd2 << 8) | 32'h1);
      for (int k = 0; k < 5; k++) push(1,0);
      for (int k = 0; sb.size() > 0; k++) begin
         e = sb.pop_front();
         n_cmp++;
         if (out_port !== e.o || irq !== e.i) begin
            n_mis++; $display("FAIL static_wave[%0d]: got out=%b irq=%b expected out=%b irq=%b", k, out_port, irq, e.o, e.i);
         end
         @(negedge clk);
      end
      rd(3'd5, d);
      n_cmp++;
      if (d !== 32'h1) begin n_mis++; $display("FAIL static_done: got %h expected 1", d); end
      wr(3'd5, 32'h1);
      wr(3'd0, 32'h0);
      n_cmp++;
      if (out_port !== 1'b0) begin n_mis++; $display("FAIL static_off: got %b expected 0", out_port); end
   endtask

   task automatic test_repeat;
      logic [31:0] d;
      exp_t e;
      wr(3'd4, 32'h1);
      wr(3'd1, 32'd2);
      wr(3'd2, 32'd2);
      wr(3'd3, (32'd1 << 8) | 32'h5);
`ifdef SYSTEM_ALARM_OUT_REPEAT_EN
      push(1,0); push(1,0); push(0,1); push(0,1); push(1,1);
      push(1,1); push(0,1); push(0,1); push(1,1); push(1,1);
`else
      push(1,0); push(1,0); push(0,1); push(0,1); push(0,1);
`endif
      for (int k = 0; sb.size() > 0; k++) begin
         e = sb.pop_front();
         n_cmp++;
         if (out_port !== e.o || irq !== e.i) begin
            n_mis++; $display("FAIL repeat_wave[%0d]: got out=%b irq=%b expected out=%b irq=%b", k, out_port, irq, e.o, e.i);
         end
         @(negedge clk);
      end
      rd(3'd3, d);
`ifdef SYSTEM_ALARM_OUT_REPEAT_EN
      n_cmp++;
      if (d !== 32'h0000_0105) begin n_mis++; $display("FAIL repeat_ctrl: got %h expected 00000105", d); end
      wr(3'd3, 32'h2);
      rd(3'd3, d);
`endif
      n_cmp++;
      if (d !== 32'h0) begin n_mis++; $display("FAIL repeat_end_ctrl: got %h expected 0", d); end
      n_cmp++;
      if (out_port !== 1'b0) begin n_mis++; $display("FAIL repeat_end_out: got %b expected 0", out_port); end
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (out_port !== 1'b0 || irq !== 1'b0 || readdata !== 32'h0) begin
         n_mis++; $display("FAIL reset_outputs: got out=%b irq=%b rd=%h expected 0 0 0", out_port, irq, readdata);
      end
      reset_n = 1'b1;
      test_reset;
      test_regs;
      test_basic;
      test_zero_len;
      test_stop;
      test_collision;
      test_static;
      test_repeat;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
